// File: rtl/riscv_mem_responder_if.sv
// riscv_mem_responder_if: fetch and data req/ack ports between an RV32I core and its memory responder
interface riscv_mem_responder_if #(parameter int XLEN = 32);
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_ack;
  logic [XLEN-1:0] if_data;
  logic            if_err;
  logic            d_req;
  logic            d_we;
  logic [3:0]      d_be;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic            d_ack;
  logic [XLEN-1:0] d_rdata;
  logic            d_err;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
    output if_ack, if_data, if_err, d_ack, d_rdata, d_err
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
    input  if_ack, if_data, if_err, d_ack, d_rdata, d_err
  );
endinterface

// File: rtl/riscv_mem_responder.sv
// riscv_mem_responder: shared single-port word memory serving fetch and data ports with wait states
module riscv_mem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input logic                 clk,
  input logic                 rst,
  riscv_mem_responder_if.slave bus
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t          state;
  logic [3:0]      cnt;
  logic            sel_if;
  logic            we;
  logic [3:0]      be;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] mem [DEPTH_WORDS];
  logic [AW-1:0]   idx;
  logic            err;
  assign idx = addr[AW+1:2];
  assign err = (|addr[1:0]) || (addr[XLEN-1:2] >= (XLEN-2)'(DEPTH_WORDS)) || (!sel_if && we && be == 4'b0);
  // Outputs are registered at the RESP edge, so the ack cycle is the IDLE cycle that follows
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sel_if      <= 1'b0;
      we          <= 1'b0;
      be          <= '0;
      addr        <= '0;
      wdata       <= '0;
      bus.if_ack  <= 1'b0;
      bus.if_err  <= 1'b0;
      bus.if_data <= '0;
      bus.d_ack   <= 1'b0;
      bus.d_err   <= 1'b0;
      bus.d_rdata <= '0;
    end else begin
      bus.if_ack  <= 1'b0;
      bus.if_err  <= 1'b0;
      bus.if_data <= '0;
      bus.d_ack   <= 1'b0;
      bus.d_err   <= 1'b0;
      bus.d_rdata <= '0;
      case (state)
        IDLE:
          if (bus.d_req || bus.if_req) begin
            sel_if <= !bus.d_req;
            addr   <= bus.d_req ? bus.d_addr : bus.if_addr;
            we     <= bus.d_req && bus.d_we;
            be     <= bus.d_be;
            wdata  <= bus.d_wdata;
            cnt    <= 4'(WAIT_STATES - 1);
            state  <= WAIT_STATES == 0 ? RESP : WAIT;
          end
        WAIT: begin
          state <= cnt == 4'd0 ? RESP : WAIT;
          cnt   <= cnt == 4'd0 ? cnt : cnt - 4'd1;
        end
        RESP: begin
          state       <= IDLE;
          bus.if_ack  <= sel_if;
          bus.if_err  <= sel_if && err;
          bus.if_data <= (sel_if && !err) ? mem[idx] : '0;
          bus.d_ack   <= !sel_if;
          bus.d_err   <= !sel_if && err;
          bus.d_rdata <= (!sel_if && !err && !we) ? mem[idx] : '0;
        end
        default: state <= IDLE;
      endcase
    end
  // Array has no reset; a reset forces IDLE so no write can land while rst is high
  always_ff @(posedge clk)
    if (state == RESP && !sel_if && we && !err)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
endmodule

// File: tb/tb_riscv_mem_responder.sv
// tb_riscv_mem_responder: directed checks of latency, byte stores, arbitration, errors and reset abort
module tb_riscv_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  logic        ifr1 = 0, dr1 = 0, dr0 = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic        d_we = 0;
  logic [3:0]  d_be = 4'hF;
  riscv_mem_responder_if #(.XLEN(32)) b1 ();
  riscv_mem_responder_if #(.XLEN(32)) b0 ();
  assign b1.if_req  = ifr1;
  assign b1.if_addr = if_addr;
  assign b1.d_req   = dr1;
  assign b1.d_we    = d_we;
  assign b1.d_be    = d_be;
  assign b1.d_addr  = d_addr;
  assign b1.d_wdata = d_wdata;
  assign b0.if_req  = 1'b0;
  assign b0.if_addr = '0;
  assign b0.d_req   = dr0;
  assign b0.d_we    = d_we;
  assign b0.d_be    = d_be;
  assign b0.d_addr  = d_addr;
  assign b0.d_wdata = d_wdata;
  riscv_mem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  riscv_mem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input bit ws0, input bit isif, input bit we, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    logic ack;
    @(negedge clk);
    d_we = we; d_be = be; d_wdata = wd;
    if (isif) begin if_addr = a; ifr1 = 1; end
    else begin d_addr = a; if (ws0) dr0 = 1; else dr1 = 1; end
    lat = 0; rd = '0; er = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      ack = isif ? b1.if_ack : (ws0 ? b0.d_ack : b1.d_ack);
      if (ack) begin
        lat = i;
        rd = isif ? b1.if_data : (ws0 ? b0.d_rdata : b1.d_rdata);
        er = isif ? b1.if_err : (ws0 ? b0.d_err : b1.d_err);
        break;
      end
    end
    ifr1 = 0; dr1 = 0; dr0 = 0; d_we = 0;
  endtask

  logic [31:0] rd, dv, iv, exp;
  logic        er, prev;
  int          lat, da, ia, nacks, consec, first;

  initial begin
    #1 rst = 1;
    @(negedge clk);
    chk("rst_flags", {b1.if_ack, b1.d_ack, b1.if_err, b1.d_err}, 64'h0);
    chk("rst_data", {b1.if_data, b1.d_rdata}, 64'h0);
    @(negedge clk); rst = 0;

    access(0, 0, 1, 4'hF, 32'h10, 32'h12345678, rd, er, lat);
    chk("pre_store_lat", lat, 3);
    @(negedge clk);
    d_we = 1; d_be = 4'hF; d_addr = 32'h10; d_wdata = 32'hDEADBEEF; dr1 = 1;
    @(posedge clk); #1;
    rst = 1; #1;
    dr1 = 0; d_we = 0;
    chk("rst_mid_flags", {b1.if_ack, b1.d_ack, b1.if_err, b1.d_err}, 64'h0);
    chk("rst_mid_data", {b1.if_data, b1.d_rdata}, 64'h0);
    @(negedge clk); @(negedge clk); rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_ack_after_rst", b1.d_ack, 0);
    end
    access(0, 0, 0, 4'hF, 32'h10, 0, rd, er, lat);
    chk("rst_abort_load", rd, 32'h12345678);

    access(0, 0, 1, 4'hF, 32'h20, 32'h11223344, rd, er, lat);
    chk("store_full_lat", lat, 3);
    chk("store_rdata_zero", rd, 0);
    access(0, 0, 1, 4'b0101, 32'h20, 32'hAABBCCDD, rd, er, lat);
    chk("store_be_lat", lat, 3);
    access(0, 0, 0, 4'hF, 32'h20, 0, rd, er, lat);
    chk("byte_merge", rd, 32'h11BB33DD);
    chk("load_lat", lat, 3);
    chk("load_err", er, 0);

    access(0, 0, 1, 4'hF, 32'h0, 32'h00000013, rd, er, lat);
    access(0, 0, 1, 4'hF, 32'h4, 32'h00100093, rd, er, lat);
    access(0, 1, 0, 4'hF, 32'h0, 0, rd, er, lat);
    chk("fetch0", rd, 32'h00000013);
    chk("fetch0_lat", lat, 3);
    @(posedge clk); #1;
    chk("fetch0_one_cycle", b1.if_ack, 0);
    access(0, 1, 0, 4'hF, 32'h4, 0, rd, er, lat);
    chk("fetch4", rd, 32'h00100093);
    chk("fetch4_err", er, 0);
    @(posedge clk); #1;
    chk("fetch4_one_cycle", b1.if_ack, 0);

    @(negedge clk);
    d_we = 0; d_addr = 32'h20; if_addr = 32'h4; dr1 = 1; ifr1 = 1;
    da = 0; ia = 0; dv = 0; iv = 0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      if (b1.d_ack) begin da = i; dv = b1.d_rdata; dr1 = 0; end
      if (b1.if_ack) begin ia = i; iv = b1.if_data; ifr1 = 0; end
    end
    dr1 = 0; ifr1 = 0;
    chk("arb_d_ack_edge", da, 3);
    chk("arb_if_ack_edge", ia, 6);
    chk("arb_d_data", dv, 32'h11BB33DD);
    chk("arb_if_data", iv, 32'h00100093);

    access(0, 0, 1, 4'hF, 32'hFFC, 32'hCAFEF00D, rd, er, lat);
    access(0, 1, 0, 4'hF, 32'h2, 0, rd, er, lat);
    chk("fetch_mis_err", er, 1);
    chk("fetch_mis_data", rd, 0);
    chk("fetch_mis_lat", lat, 3);
    access(0, 0, 0, 4'hF, 32'h5, 0, rd, er, lat);
    chk("load_mis_err", er, 1);
    chk("load_mis_data", rd, 0);
    access(0, 0, 1, 4'hF, 32'h1000, 32'hFFFFFFFF, rd, er, lat);
    chk("store_oor_err", er, 1);
    chk("store_oor_data", rd, 0);
    chk("store_oor_lat", lat, 3);
    access(0, 0, 1, 4'h0, 32'h20, 32'h0, rd, er, lat);
    chk("store_be0_err", er, 1);
    access(0, 0, 0, 4'hF, 32'hFFC, 0, rd, er, lat);
    chk("last_word_kept", rd, 32'hCAFEF00D);
    chk("last_word_err", er, 0);
    access(0, 1, 0, 4'hF, 32'h0, 0, rd, er, lat);
    chk("word0_kept", rd, 32'h00000013);
    access(0, 0, 0, 4'hF, 32'h20, 0, rd, er, lat);
    chk("be0_no_write", rd, 32'h11BB33DD);

    access(1, 0, 1, 4'hF, 32'h0, 32'hA5A5A5A5, rd, er, lat);
    chk("ws0_store_lat", lat, 2);
    access(1, 0, 1, 4'hF, 32'h4, 32'h5A5A5A5A, rd, er, lat);
    @(negedge clk);
    d_we = 0; d_addr = 32'h0; dr0 = 1;
    exp = 32'hA5A5A5A5; prev = 0; nacks = 0; consec = 0; first = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (b0.d_ack) begin
        nacks++;
        if (prev) consec++;
        if (first == 0) first = i;
        chk("ws0_data", b0.d_rdata, exp);
        d_addr = d_addr ^ 32'h4;
        exp = d_addr == 32'h0 ? 32'hA5A5A5A5 : 32'h5A5A5A5A;
      end
      prev = b0.d_ack;
    end
    dr0 = 0;
    chk("ws0_ack_count", nacks, 6);
    chk("ws0_no_consecutive", consec, 0);
    chk("ws0_first_ack", first, 2);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
